// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared FSM encodings, scoreboard entry type and helpers for the hazard controller.
package rv_pipe_pkg;
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       mem_read;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hardwired to zero, so it never matches as a source
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && (e.rd == rs) && (rs != REG_ZERO);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + ONE;
  assign count = r_count;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-based stall/flush sequencing for the 5-stage pipeline,
// with post-reset warm-up and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter bit FORWARDING_EN    = 1'b0,
  parameter bit RF_WRITE_THROUGH = 1'b0,
  parameter int INIT_CYCLES      = 2,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 ex_redirect,
  output logic                 pc_write_en,
  output logic                 ifid_write_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [1:0]           ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_e    r_state, w_next;
  logic [3:0] r_init_cnt;
  sb_entry_t r_ex, r_mem, r_wb;
  logic      w_init, w_hz_rs1, w_hz_rs2, w_hazard, w_redirect, w_stall;

  assign w_init = (r_state == ST_INIT);

  // With forwarding only a load still in EX cannot be bypassed in time
  assign w_hz_rs1 = FORWARDING_EN ? (r_ex.mem_read & sb_match(r_ex, id_rs1))
                  : (sb_match(r_ex, id_rs1) | sb_match(r_mem, id_rs1) | (!RF_WRITE_THROUGH & sb_match(r_wb, id_rs1)));
  assign w_hz_rs2 = FORWARDING_EN ? (r_ex.mem_read & sb_match(r_ex, id_rs2))
                  : (sb_match(r_ex, id_rs2) | sb_match(r_mem, id_rs2) | (!RF_WRITE_THROUGH & sb_match(r_wb, id_rs2)));
  assign w_hazard   = !w_init & id_valid & ((id_uses_rs1 & w_hz_rs1) | (id_uses_rs2 & w_hz_rs2));
  assign w_redirect = !w_init & ex_redirect;
  assign w_stall    = w_hazard & !w_redirect;

  always_comb begin
    w_next        = ST_RUN;
    pc_write_en   = !w_init & !w_stall;
    ifid_write_en = !w_init & !w_stall;
    ifid_flush    = w_init | w_redirect;
    idex_flush    = w_init | w_redirect | w_hazard;
    if (w_init) w_next = (r_init_cnt == INIT_LAST) ? ST_RUN : ST_INIT;
    else w_next = w_redirect ? ST_FLUSH : (w_hazard ? ST_STALL : ST_RUN);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= w_init ? r_init_cnt + 4'd1 : '0;
    end

  // A stalled or wrong-path ID instruction must not be tracked as in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= '{valid:    id_valid & id_reg_write & (id_rd != REG_ZERO) & !w_init & !w_hazard & !w_redirect,
                 rd:       id_rd,
                 mem_read: id_mem_read};
    end

  assign ctrl_state = r_state;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(w_stall), .count(stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(w_redirect), .count(flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: two configurations (full interlock / forwarding+write-through, 4-bit counters)
// driven by directed and random stimulus, checked against an in-bench reference model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 0, u1 = 0, u2 = 0, rw = 0, mr = 0, redir = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;

  logic pc_a, ifw_a, iff_a, idf_a, pc_b, ifw_b, iff_b, idf_b;
  logic [1:0] st_a, st_b;
  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  pipeline_hazard_ctrl #(.FORWARDING_EN(1'b0), .RF_WRITE_THROUGH(1'b0), .INIT_CYCLES(2), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_rd(rd), .id_reg_write(rw), .id_mem_read(mr),
    .ex_redirect(redir), .pc_write_en(pc_a), .ifid_write_en(ifw_a), .ifid_flush(iff_a),
    .idex_flush(idf_a), .ctrl_state(st_a), .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_hazard_ctrl #(.FORWARDING_EN(1'b1), .RF_WRITE_THROUGH(1'b1), .INIT_CYCLES(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_rd(rd), .id_reg_write(rw), .id_mem_read(mr),
    .ex_redirect(redir), .pc_write_en(pc_b), .ifid_write_en(ifw_b), .ifid_flush(iff_b),
    .idex_flush(idf_b), .ctrl_state(st_b), .stall_count(sc_b), .flush_count(fc_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int i, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
  endtask

  // Reference model: per instance, the list of in-flight writers (0=EX,1=MEM,2=WB) and a warm-up count
  int     p_fwd[2]  = '{0, 1};
  int     p_wt[2]   = '{0, 1};
  int     p_init[2] = '{2, 3};
  longint cmax[2]   = '{64'hFFFF_FFFF, 64'd15};
  bit         in_init[2];
  int         ic[2];
  int         st[2];
  bit         ev[2][3];
  logic [4:0] erd[2][3];
  bit         eld[2][3];
  longint     sc[2], fc[2];

  function automatic bit model_hz(int i);
    bit h = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!ev[i][k]) continue;
      if (p_wt[i] != 0 && k == 2) continue;
      if (p_fwd[i] != 0 && (k != 0 || !eld[i][k])) continue;
      if (u1 && rs1 != 0 && erd[i][k] == rs1) h = 1'b1;
      if (u2 && rs2 != 0 && erd[i][k] == rs2) h = 1'b1;
    end
    return h && id_valid;
  endfunction

  task automatic model_reset(int i);
    in_init[i] = 1; ic[i] = 0; st[i] = 0; sc[i] = 0; fc[i] = 0;
    for (int k = 0; k < 3; k++) begin ev[i][k] = 0; erd[i][k] = 0; eld[i][k] = 0; end
  endtask

  task automatic check_inst(int i);
    logic [5:0] got, exp;
    longint gs, gf;
    bit h, r, newv;
    got = (i == 0) ? {pc_a, ifw_a, iff_a, idf_a, st_a} : {pc_b, ifw_b, iff_b, idf_b, st_b};
    gs  = (i == 0) ? longint'(sc_a) : longint'(sc_b);
    gf  = (i == 0) ? longint'(fc_a) : longint'(fc_b);
    if (!reset) begin
      model_reset(i);
      chk("reset_outputs", i, longint'(got), longint'(6'b001100));
      chk("reset_counters", i, gs + gf, 0);
    end else begin
      h = !in_init[i] && model_hz(i);
      r = !in_init[i] && redir;
      if (in_init[i]) exp = {4'b0011, 2'(st[i])};
      else if (r)     exp = {4'b1111, 2'(st[i])};
      else if (h)     exp = {4'b0001, 2'(st[i])};
      else            exp = {4'b1100, 2'(st[i])};
      chk("outputs", i, longint'(got), longint'(exp));
      chk("stall_count", i, gs, sc[i]);
      chk("flush_count", i, gf, fc[i]);
      newv = id_valid && rw && rd != 0 && !h && !r && !in_init[i];
      for (int k = 2; k > 0; k--) begin ev[i][k] = ev[i][k-1]; erd[i][k] = erd[i][k-1]; eld[i][k] = eld[i][k-1]; end
      ev[i][0] = newv; erd[i][0] = rd; eld[i][0] = mr;
      if (in_init[i]) begin
        ic[i]++;
        if (ic[i] == p_init[i]) begin in_init[i] = 0; st[i] = 1; end
      end else begin
        if (h && !r && sc[i] != cmax[i]) sc[i]++;
        if (r && fc[i] != cmax[i]) fc[i]++;
        st[i] = r ? 3 : (h ? 2 : 1);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                       input logic [4:0] d, input logic w, input logic m, input logic x);
    @(negedge clk);
    id_valid = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; rw = w; mr = m; redir = x;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    id_valid = 0; u1 = 0; u2 = 0; rw = 0; mr = 0; redir = 0;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    // warm-up after reset release
    do_reset();
    #1 chk("warmup_c0_state", 0, longint'(st_a), 0);
    chk("warmup_c0_flush", 0, longint'({pc_a, iff_a, idf_a}), longint'(3'b011));
    idle(); #1 chk("warmup_c1_state", 0, longint'(st_a), 0);
    idle(); #1 chk("warmup_c2_run", 0, longint'(st_a), 1);
    chk("warmup_c2_b_init", 1, longint'(st_b), 0);
    idle(); #1 chk("warmup_c3_b_run", 1, longint'(st_b), 1);
    chk("warmup_counters", 0, longint'(sc_a) + longint'(fc_a), 0);
    // load-use: lw x5 ; add x6,x5,x7 held in ID while stalled
    drive(1, 0, 0, 1, 0, 5, 1, 1, 0);
    drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
    #1 chk("ld_use_b_stall", 1, longint'({pc_b, idf_b}), longint'(2'b01));
    chk("ld_use_a_stall", 0, longint'(pc_a), 0);
    drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
    #1 chk("ld_use_b_resume", 1, longint'({pc_b, st_b}), longint'(3'b110));
    chk("ld_use_b_count", 1, longint'(sc_b), 1);
    drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
    drive(1, 5, 7, 1, 1, 6, 1, 0, 0);
    #1 chk("interlock_a_count", 0, longint'(sc_a), 3);
    chk("interlock_a_resume", 0, longint'(pc_a), 1);
    chk("interlock_b_count", 1, longint'(sc_b), 1);
    // redirect in the same cycle as a hazard
    do_reset(); repeat (3) idle();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drive(1, 5, 7, 1, 1, 6, 1, 0, 1);
    #1 chk("redir_a_out", 0, longint'({pc_a, ifw_a, iff_a, idf_a}), longint'(4'b1111));
    chk("redir_b_out", 1, longint'({pc_b, ifw_b, iff_b, idf_b}), longint'(4'b1111));
    drive(1, 5, 0, 1, 0, 8, 1, 0, 0);
    #1 chk("redir_a_flush_cnt", 0, longint'(fc_a), 1);
    chk("redir_b_flush_cnt", 1, longint'(fc_b), 1);
    chk("redir_b_stall_cnt", 1, longint'(sc_b), 0);
    chk("redir_b_state", 1, longint'(st_b), 3);
    chk("redir_b_ex_cleared", 1, longint'(pc_b), 1);
    chk("redir_a_mem_hazard", 0, longint'(pc_a), 0);
    // x0 as destination and source
    do_reset(); repeat (3) idle();
    drive(1, 0, 0, 1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0);
    #1 chk("x0_a_nostall", 0, longint'(pc_a), 1);
    chk("x0_b_nostall", 1, longint'(pc_b), 1);
    // saturation: 20 load-use pairs
    do_reset(); repeat (3) idle();
    repeat (20) begin
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
      drive(1, 5, 5, 1, 1, 6, 1, 0, 0);
    end
    idle();
    #1 chk("sat_b_count", 1, longint'(sc_b), 15);
    chk("sat_a_count", 0, longint'(sc_a), 20);
    // asynchronous reset between edges while stalling
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0);
    @(posedge clk);
    #3 reset = 0;
    #1 chk("async_a_out", 0, longint'({pc_a, ifw_a, iff_a, idf_a, st_a}), longint'(6'b001100));
    chk("async_b_out", 1, longint'({pc_b, ifw_b, iff_b, idf_b, st_b}), longint'(6'b001100));
    chk("async_counts", 1, longint'(sc_b) + longint'(sc_a) + longint'(fc_a), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    // random traffic with occasional resets and redirects
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) != 0);
      id_valid = ($urandom_range(0, 4) != 0);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      rd       = 5'($urandom_range(0, 7));
      u1       = 1'($urandom);
      u2       = 1'($urandom);
      rw       = ($urandom_range(0, 3) != 0);
      mr       = ($urandom_range(0, 2) == 0);
      redir    = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
